frame_writer: RTL

FRAME_WRITER -- requirements
Module: frame_writer

---
 rtl/frame_writer_if.sv | 31 +++
 rtl/frame_writer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/frame_writer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_writer_if                                                      |
// | Pixel plot / clear request bus and frame RAM write port.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface frame_writer_if;
    logic        plot;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colourIn;
    logic        clear;
    logic [2:0]  clearColour;
    logic        ready;
    logic        busy;
    logic [14:0] ramAddress;
    logic [2:0]  ramData;
    logic        ramWren;
    logic [7:0]  dropCount;

    modport master (
        output plot, x, y, colourIn, clear, clearColour,
        input  ready, busy, ramAddress, ramData, ramWren, dropCount
    );

    modport slave (
        input  plot, x, y, colourIn, clear, clearColour,
        output ready, busy, ramAddress, ramData, ramWren, dropCount
    );
endinterface
`default_nettype wire

// File: rtl/frame_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_writer                                                         |
// | 160x120x3 frame RAM writer: pipelined pixel plots and screen fill.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module frame_writer (
    input  wire logic      clk,
    input  wire logic      rst,
    frame_writer_if.slave  fw
);

    localparam logic [7:0]  c_WIDTH     = 8'd160;
    localparam logic [6:0]  c_HEIGHT    = 7'd120;
    localparam logic [14:0] c_LAST_ADDR = 15'd19199;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FILL  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_drain_cnt;
    logic [14:0] r_fill_addr;
    logic [2:0]  r_fill_col;

    // stage 1: raw accepted plot
    logic        r_s1_vld;
    logic [7:0]  r_s1_x;
    logic [6:0]  r_s1_y;
    logic [2:0]  r_s1_col;
    // stage 2: resolved address/data
    logic        r_s2_wr;
    logic [14:0] r_s2_addr;
    logic [2:0]  r_s2_data;
    // registered plot write port
    logic        r_wr;
    logic [14:0] r_addr;
    logic [2:0]  r_data;
    logic [7:0]  r_drop;

    logic        w_idle;
    logic        w_accept;
    logic        w_s1_inrange;
    logic [14:0] w_y15;
    logic [14:0] w_s1_addr;

    assign w_idle       = (r_state == ST_IDLE);
    assign w_accept     = w_idle && !fw.clear && fw.plot;
    assign w_s1_inrange = (r_s1_x < c_WIDTH) && (r_s1_y < c_HEIGHT);

    // y*160 = y*128 + y*32
    assign w_y15     = {8'd0, r_s1_y};
    assign w_s1_addr = (w_y15 << 7) + (w_y15 << 5) + {7'd0, r_s1_x};

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (fw.clear)                 w_next = ST_DRAIN;
            ST_DRAIN: if (r_drain_cnt)              w_next = ST_FILL;
            ST_FILL:  if (r_fill_addr == c_LAST_ADDR) w_next = ST_IDLE;
            default:                                w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= 1'b0;
            r_fill_addr <= 15'd0;
            r_fill_col  <= 3'd0;
        end else begin
            r_state     <= w_next;
            r_drain_cnt <= (r_state == ST_DRAIN) ? ~r_drain_cnt : 1'b0;
            r_fill_addr <= (r_state == ST_FILL && w_next == ST_FILL) ? r_fill_addr + 15'd1 : 15'd0;
            if (w_idle && fw.clear) begin
                r_fill_col <= fw.clearColour;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_x    <= 8'd0;
            r_s1_y    <= 7'd0;
            r_s1_col  <= 3'd0;
            r_s2_wr   <= 1'b0;
            r_s2_addr <= 15'd0;
            r_s2_data <= 3'd0;
            r_wr      <= 1'b0;
            r_addr    <= 15'd0;
            r_data    <= 3'd0;
            r_drop    <= 8'd0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_x   <= fw.x;
                r_s1_y   <= fw.y;
                r_s1_col <= fw.colourIn;
            end

            // out-of-range plots still occupy their slot, just without a write
            r_s2_wr   <= r_s1_vld && w_s1_inrange;
            r_s2_addr <= (r_s1_vld && w_s1_inrange) ? w_s1_addr : 15'd0;
            r_s2_data <= (r_s1_vld && w_s1_inrange) ? r_s1_col  : 3'd0;

            if (r_s1_vld && !w_s1_inrange && r_drop != 8'hFF) begin
                r_drop <= r_drop + 8'd1;
            end

            r_wr   <= r_s2_wr;
            r_addr <= r_s2_addr;
            r_data <= r_s2_data;
        end
    end

    // DRAIN guarantees the plot pipeline is empty before FILL owns the port
    assign fw.ready      = w_idle && !fw.clear;
    assign fw.busy       = !w_idle;
    assign fw.ramWren    = (r_state == ST_FILL) || r_wr;
    assign fw.ramAddress = (r_state == ST_FILL) ? r_fill_addr : r_addr;
    assign fw.ramData    = (r_state == ST_FILL) ? r_fill_col  : r_data;
    assign fw.dropCount  = r_drop;

endmodule
`default_nettype wire
